// File: rtl/imm_pkg.sv
// Shared immediate-extension mode definitions.
// The ID decoder uses the same type to drive in_mode.
package imm_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'd0,
        MODE_SIGN   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } mode_t;

    localparam int MODE_W = 2;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender.
// Implements the zero, sign, upper (LUI) and branch-offset forms.
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]  i_imm,
    input  mode_t            i_mode,
    output logic [OUT_W-1:0] o_imm
);

    logic [OUT_W-1:0] w_zero;
    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_branch;

    assign w_zero   = {{(OUT_W-IN_W){1'b0}}, i_imm};
    assign w_sign   = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
    assign w_upper  = {i_imm, {(OUT_W-IN_W){1'b0}}};
    // Bits shifted past the MSB are dropped.
    assign w_branch = w_sign << BR_SHIFT;

    always_comb begin
        o_imm = w_zero;
        case (i_mode)
            MODE_ZERO:   o_imm = w_zero;
            MODE_SIGN:   o_imm = w_sign;
            MODE_UPPER:  o_imm = w_upper;
            MODE_BRANCH: o_imm = w_branch;
            default:     o_imm = w_zero;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender for the ID/EX boundary.
// The valid/ready interface uses a main register plus one skid register.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);

    logic             r_main_valid;
    logic [OUT_W-1:0] r_main_imm;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_skid_valid;
    logic [OUT_W-1:0] r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_in_ready;

    logic [OUT_W-1:0] w_ext_imm;
    logic             w_in_xfer;
    logic             w_out_xfer;

    logic             w_main_valid_next;
    logic [OUT_W-1:0] w_main_imm_next;
    logic [TAG_W-1:0] w_main_tag_next;
    logic             w_skid_valid_next;
    logic [OUT_W-1:0] w_skid_imm_next;
    logic [TAG_W-1:0] w_skid_tag_next;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .i_imm  (in_imm),
        .i_mode (mode_t'(in_mode)),
        .o_imm  (w_ext_imm)
    );

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_main_valid && out_ready;

    always_comb begin
        w_main_valid_next = r_main_valid;
        w_main_imm_next   = r_main_imm;
        w_main_tag_next   = r_main_tag;
        w_skid_valid_next = r_skid_valid;
        w_skid_imm_next   = r_skid_imm;
        w_skid_tag_next   = r_skid_tag;

        if (!r_main_valid || w_out_xfer) begin
            // The skid entry is always older than any new input.
            if (r_skid_valid) begin
                w_main_valid_next = 1'b1;
                w_main_imm_next   = r_skid_imm;
                w_main_tag_next   = r_skid_tag;
                w_skid_valid_next = 1'b0;
            end else if (w_in_xfer) begin
                w_main_valid_next = 1'b1;
                w_main_imm_next   = w_ext_imm;
                w_main_tag_next   = in_tag;
            end else begin
                w_main_valid_next = 1'b0;
            end
        end else if (w_in_xfer) begin
            w_skid_valid_next = 1'b1;
            w_skid_imm_next   = w_ext_imm;
            w_skid_tag_next   = in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_tag   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_tag   <= '0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_next;
            r_main_imm   <= w_main_imm_next;
            r_main_tag   <= w_main_tag_next;
            r_skid_valid <= w_skid_valid_next;
            r_skid_imm   <= w_skid_imm_next;
            r_skid_tag   <= w_skid_tag_next;
            r_in_ready   <= !w_skid_valid_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_imm   = r_main_imm;
    assign out_tag   = r_main_tag;

endmodule
